// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache with req/ack memory port
module dcache_dm #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [31:0]             data_arr [LINES*4];

  logic [1:0]              offset;
  logic [INDEX_BITS-1:0]   index;
  logic [TAG_W-1:0]        tag;
  logic                    hit;

  logic [1:0]              cnt;
  logic [TAG_W-1:0]        fill_tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic                    req_q, we_q;
  logic [31:0]             adr_q, wdata_q;

  logic                    idle_wr, idle_miss, fill_ack, fill_last;
  logic                    d_we;
  logic [INDEX_BITS+1:0]   d_addr;
  logic [31:0]             d_val;
  logic                    unused_bits;

  assign offset      = cpu_adr[3:2];
  assign index       = cpu_adr[INDEX_BITS+3:4];
  assign tag         = cpu_adr[31:INDEX_BITS+4];
  assign hit         = valid[index] && (tag_arr[index] == tag);
  assign unused_bits = ^cpu_adr[1:0];

  assign idle_wr   = (state == IDLE) && cpu_wr;
  assign idle_miss = (state == IDLE) && !cpu_wr && cpu_rd && !hit;
  assign fill_ack  = (state == REFILL) && mem_ack;
  assign fill_last = fill_ack && (cnt == 2'd3);

  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    if (!rst) begin
      stall = idle_wr || idle_miss || (state == REFILL) || ((state == WRITE) && !mem_ack);
      if ((state == IDLE) && cpu_rd && !cpu_wr && hit)
        cpu_rdata = data_arr[{index, offset}];
    end
  end

  // Store hits and refill beats never coincide, so the data array needs one write port.
  always_comb begin
    d_we   = 1'b0;
    d_addr = {index, offset};
    d_val  = cpu_wdata;
    if (!rst) begin
      if (idle_wr && hit) begin
        d_we = 1'b1;
      end else if (fill_ack) begin
        d_we   = 1'b1;
        d_addr = {fill_index, cnt};
        d_val  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (d_we)
      data_arr[d_addr] <= d_val;
    if (!rst && fill_last)
      tag_arr[fill_index] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      cnt     <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            state   <= WRITE;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= {cpu_adr[31:2], 2'b00};
            wdata_q <= cpu_wdata;
          end else if (cpu_rd && !hit) begin
            // Drop the victim's valid bit now so an aborted refill leaves no stale line.
            state         <= REFILL;
            valid[index]  <= 1'b0;
            fill_tag      <= tag;
            fill_index    <= index;
            cnt           <= 2'd0;
            req_q         <= 1'b1;
            we_q          <= 1'b0;
            adr_q         <= {tag, index, 4'b0000};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt   <= cnt + 2'd1;
            adr_q <= {fill_tag, fill_index, cnt + 2'd1, 2'b00};
            if (cnt == 2'd3) begin
              valid[fill_index] <= 1'b1;
              state             <= IDLE;
              req_q             <= 1'b0;
              adr_q             <= '0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req   = req_q && !rst;
  assign mem_we    = we_q && !rst;
  assign mem_adr   = rst ? '0 : adr_q;
  assign mem_wdata = rst ? '0 : wdata_q;
endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - self-checking bench for dcache_dm with a line-presence model and backing memory
module tb_dcache_dm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_adr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  dcache_dm #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: explicit words override a hashed default pattern
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_arr.exists(w)) return mem_arr[w];
    return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    int          waits;
    int          cycles;
  } txn_t;
  txn_t txq[$];

  int          forced_wait = 0;
  logic        busy = 1'b0;
  logic [31:0] r_adr, r_wd;
  logic        r_we;
  int          wait_left, r_waits, r_cycles;

  // Memory responder: drives after the DUT's registered outputs have settled
  always @(posedge clk) begin
    #2;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        r_adr     = mem_adr;
        r_we      = mem_we;
        r_wd      = mem_wdata;
        r_waits   = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
        wait_left = r_waits;
        r_cycles  = 0;
      end else begin
        chk("hs_adr", mem_adr, r_adr);
        chk("hs_we", 32'(mem_we), 32'(r_we));
        chk("hs_wdata", mem_wdata, r_wd);
      end
      r_cycles++;
      if (wait_left == 0) begin
        mem_ack = 1'b1;
        if (r_we) mem_arr[r_adr] = r_wd;
        else      mem_rdata = mem_val(r_adr);
        txq.push_back('{r_we, r_adr, r_wd, r_waits, r_cycles});
        busy = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      busy = 1'b0;
    end
  end

  // Every-cycle output checks
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_adr", mem_adr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    end else begin
      if (!mem_req) begin
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_mem_adr", mem_adr, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end
      if (cpu_rd && !cpu_wr && !stall)
        chk("rdata", cpu_rdata, mem_val(cpu_adr));
      if (!cpu_rd && !cpu_wr) begin
        chk("noop_stall", 32'(stall), 32'd0);
        chk("noop_rdata", cpu_rdata, 32'd0);
      end
    end
  end

  // Cache contents model: which block occupies each line
  logic        mv [16];
  logic [23:0] mt [16];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0;
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
    int   idx;
    logic exp_hit;
    int   exp_stall;
    idx     = int'(a[7:4]);
    exp_hit = mv[idx] && (mt[idx] == a[31:8]);
    txq.delete();
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_adr = a; cpu_wdata = wd;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      if (stalls >= 200) begin
        checks++; failures++;
        $display("FAIL op_timeout actual=stalled required=done adr=%h", a);
        break;
      end
    end
    rdata = cpu_rdata;
    if (wr) begin
      chk("wr_txns", txq.size(), 32'd1);
      if (txq.size() == 1) begin
        chk("wr_we", 32'(txq[0].we), 32'd1);
        chk("wr_adr", txq[0].adr, {a[31:2], 2'b00});
        chk("wr_wdata", txq[0].wdata, wd);
        chk("wr_stall", stalls, 1 + txq[0].waits);
      end
    end else if (rd) begin
      if (exp_hit) begin
        chk("hit_stall", stalls, 32'd0);
        chk("hit_txns", txq.size(), 32'd0);
      end else begin
        chk("miss_txns", txq.size(), 32'd4);
        exp_stall = 1;
        for (int i = 0; i < txq.size() && i < 4; i++) begin
          chk("miss_we", 32'(txq[i].we), 32'd0);
          chk("miss_adr", txq[i].adr, {a[31:4], 4'b0000} + 32'(4 * i));
          exp_stall += txq[i].waits + 1;
        end
        chk("miss_stall", stalls, exp_stall);
        mv[idx] = 1'b1;
        mt[idx] = a[31:8];
      end
      chk("op_rdata", rdata, mem_val(a));
    end
  endtask

  int          st;
  logic [31:0] rd_v;
  int          acks;
  logic [31:0] ra;

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    model_clear();
    mem_arr[32'h40] = 32'h11;
    mem_arr[32'h44] = 32'h22;
    mem_arr[32'h48] = 32'h33;
    mem_arr[32'h4C] = 32'h44;
    forced_wait = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold load with ack every cycle
    do_op(1'b1, 1'b0, 32'h40, 32'h0, st, rd_v);
    chk("load_stall5", st, 32'd5);
    chk("load_txns", txq.size(), 32'd4);
    if (txq.size() == 4) begin
      chk("load_a0", txq[0].adr, 32'h40);
      chk("load_a1", txq[1].adr, 32'h44);
      chk("load_a2", txq[2].adr, 32'h48);
      chk("load_a3", txq[3].adr, 32'h4C);
    end
    chk("load_data", rd_v, 32'h11);

    do_op(1'b1, 1'b0, 32'h48, 32'h0, st, rd_v);
    chk("same_blk_data", rd_v, 32'h33);
    chk("same_blk_stall", st, 32'd0);
    chk("same_blk_txns", txq.size(), 32'd0);

    // Write hit with two wait cycles
    forced_wait = 2;
    do_op(1'b0, 1'b1, 32'h44, 32'hDEAD, st, rd_v);
    chk("wrhit_txns", txq.size(), 32'd1);
    if (txq.size() == 1) begin
      chk("wrhit_adr", txq[0].adr, 32'h44);
      chk("wrhit_req_cycles", txq[0].cycles, 32'd3);
    end
    chk("wrhit_stall", st, 32'd3);
    forced_wait = 0;
    do_op(1'b1, 1'b0, 32'h44, 32'h0, st, rd_v);
    chk("wrhit_readback", rd_v, 32'hDEAD);
    chk("wrhit_read_stall", st, 32'd0);

    // Conflict miss between aliasing blocks
    do_op(1'b1, 1'b0, 32'h440, 32'h0, st, rd_v);
    chk("conflict_stall", st, 32'd5);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, st, rd_v);
    chk("conflict_remiss", st, 32'd5);
    chk("conflict_data", rd_v, 32'h11);

    // Reset after the second refill ack
    do_reset();
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_adr = 32'h40;
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    chk("midfill_acks", acks, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midfill_req_low", 32'(mem_req), 32'd0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, st, rd_v);
    chk("midfill_full_txns", txq.size(), 32'd4);
    chk("midfill_stall", st, 32'd5);
    chk("midfill_data", rd_v, 32'h11);

    // Write miss on a cold cache
    do_reset();
    do_op(1'b0, 1'b1, 32'h80, 32'h5, st, rd_v);
    if (txq.size() == 1) begin
      chk("wrmiss_adr", txq[0].adr, 32'h80);
      chk("wrmiss_wdata", txq[0].wdata, 32'h5);
    end
    chk("wrmiss_stall", st, 32'd1);
    do_op(1'b1, 1'b0, 32'h80, 32'h0, st, rd_v);
    chk("wrmiss_read_miss", st, 32'd5);
    chk("wrmiss_read_data", rd_v, 32'h5);

    // Randomized mix with random memory latency
    forced_wait = -1;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          k;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 28)
          | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
      k = int'($urandom_range(0, 9));
      if (k < 6)      do_op(1'b1, 1'b0, a, 32'h0, st, rd_v);
      else if (k < 9) do_op(1'b0, 1'b1, a, $urandom, st, rd_v);
      else            do_op(1'b1, 1'b1, a, $urandom, st, rd_v);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
